my_uart_rx_frame: RTL and testbench

//  - UART receiver and frame decoder for the 11-byte tracking telemetry frame produced by the camera board TX.
//  - Rebuilds the object centre, angles and rotation direction, then presents them as one atomic register set.
//  - Sits on the host/peer FPGA: rs232_rx comes from the pin, decoded outputs feed the servo/display logic.

---
 rtl/my_uart_rx_frame_if.sv | 25 ++
 rtl/my_uart_rx_frame.sv | 201 ++++++++++++++++++++
 tb/tb_my_uart_rx_frame.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/my_uart_rx_frame_if.sv
// Decoded telemetry register set of my_uart_rx_frame.
// master: the receiver drives the decoded frame. slave: the servo/display logic reads it.
interface my_uart_rx_frame_if;
  localparam int unsigned POS_W = 12;
  localparam int unsigned ANG_W = 10;

  logic [POS_W-1:0] centre_pos_x;
  logic [POS_W-1:0] centre_pos_y;
  logic [ANG_W-1:0] angle_x;
  logic [ANG_W-1:0] angle_y;
  logic             chieu_xoay;
  logic             frame_valid;
  logic             frame_err;
  logic             rx_busy;

  modport master (
    output centre_pos_x, centre_pos_y, angle_x, angle_y,
    output chieu_xoay, frame_valid, frame_err, rx_busy
  );

  modport slave (
    input centre_pos_x, centre_pos_y, angle_x, angle_y,
    input chieu_xoay, frame_valid, frame_err, rx_busy
  );
endinterface

// File: rtl/my_uart_rx_frame.sv
// UART receiver and decoder for the 11-byte tracking telemetry frame
// (FF FF xl xh yl yh axl axh ayl ayh dir). Completed frames update the
// output register set atomically.
// Optional build macro: UART_RX_FRAME_CHECK_EN -- when defined, frames whose
// reserved bits (xh/yh/axh/ayh[7:2], dir[7:1]) are nonzero are dropped.
module my_uart_rx_frame #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rs232_rx,
  my_uart_rx_frame_if.master frm
);

  localparam int unsigned       HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [7:0]        SYNC_BYTE = 8'hFF;
`ifdef UART_RX_FRAME_CHECK_EN
  localparam int unsigned       HI_W      = 8;
`else
  localparam int unsigned       HI_W      = 2;
`endif

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
  typedef enum logic [1:0] {F_SYNC1, F_SYNC2, F_PAYLOAD} fstate_t;

  logic             sync1_q, sync2_q, rx_prev_q;
  logic             rx_s;
  bstate_t          bstate_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             byte_done_q, byte_ferr_q;

  fstate_t          fstate_q;
  logic [3:0]       idx_q;
  logic [7:0]       xl_q, yl_q, axl_q, ayl_q;
  logic [HI_W-1:0]  xh_q, yh_q, axh_q, ayh_q;
  logic             rsvd_bad;

  logic [11:0]      pos_x_q, pos_y_q;
  logic [9:0]       ang_x_q, ang_y_q;
  logic             dir_q, valid_q, err_q;

  assign rx_s = sync2_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rs232_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Byte FSM: mid-bit sampling; a stop error leaves the line low, so the next
  // falling edge cannot occur until the line has returned high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate_q    <= B_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      byte_ferr_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      byte_ferr_q <= 1'b0;
      case (bstate_q)
        B_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            bstate_q <= B_START;
            cnt_q    <= '0;
          end
        end
        B_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            bstate_q <= rx_s ? B_IDLE : B_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) bstate_q <= B_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q       <= '0;
            bstate_q    <= B_IDLE;
            byte_done_q <= rx_s;
            byte_ferr_q <= !rx_s;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: bstate_q <= B_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FRAME_CHECK_EN
  // The dir byte is still in shift_q when it completes.
  assign rsvd_bad = (|xh_q[7:2]) | (|yh_q[7:2]) | (|axh_q[7:2]) |
                    (|ayh_q[7:2]) | (|shift_q[7:1]);
`else
  assign rsvd_bad = 1'b0;
`endif

  // Frame FSM: FF FF sync, nine payload bytes into shadows, atomic output load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fstate_q <= F_SYNC1;
      idx_q    <= '0;
      xl_q     <= '0;
      yl_q     <= '0;
      axl_q    <= '0;
      ayl_q    <= '0;
      xh_q     <= '0;
      yh_q     <= '0;
      axh_q    <= '0;
      ayh_q    <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      ang_x_q  <= '0;
      ang_y_q  <= '0;
      dir_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (byte_ferr_q) begin
        if (fstate_q != F_SYNC1) begin
          err_q    <= 1'b1;
          fstate_q <= F_SYNC1;
        end
      end else if (byte_done_q) begin
        case (fstate_q)
          F_SYNC1: if (shift_q == SYNC_BYTE) fstate_q <= F_SYNC2;
          F_SYNC2: begin
            idx_q    <= '0;
            fstate_q <= (shift_q == SYNC_BYTE) ? F_PAYLOAD : F_SYNC1;
          end
          F_PAYLOAD: begin
            idx_q <= idx_q + 1'b1;
            case (idx_q)
              4'd0: xl_q  <= shift_q;
              4'd1: xh_q  <= shift_q[HI_W-1:0];
              4'd2: yl_q  <= shift_q;
              4'd3: yh_q  <= shift_q[HI_W-1:0];
              4'd4: axl_q <= shift_q;
              4'd5: axh_q <= shift_q[HI_W-1:0];
              4'd6: ayl_q <= shift_q;
              4'd7: ayh_q <= shift_q[HI_W-1:0];
              default: begin
                fstate_q <= F_SYNC1;
                if (rsvd_bad) begin
                  err_q <= 1'b1;
                end else begin
                  pos_x_q <= {xh_q[1:0], xl_q, 2'b00};
                  pos_y_q <= {yh_q[1:0], yl_q, 2'b00};
                  ang_x_q <= {axh_q[1:0], axl_q};
                  ang_y_q <= {ayh_q[1:0], ayl_q};
                  dir_q   <= shift_q[0];
                  valid_q <= 1'b1;
                end
              end
            endcase
          end
          default: fstate_q <= F_SYNC1;
        endcase
      end
    end
  end

  assign frm.centre_pos_x = pos_x_q;
  assign frm.centre_pos_y = pos_y_q;
  assign frm.angle_x      = ang_x_q;
  assign frm.angle_y      = ang_y_q;
  assign frm.chieu_xoay   = dir_q;
  assign frm.frame_valid  = valid_q;
  assign frm.frame_err    = err_q;
  // Pure decode of state registers.
  assign frm.rx_busy      = (fstate_q != F_SYNC1) || (bstate_q != B_IDLE);

endmodule

// File: tb/tb_my_uart_rx_frame.sv
// Directed bench for my_uart_rx_frame: table of full frames plus hand-written
// corner sequences (glitch, stop error, garbage before sync, mid-frame reset).
module tb_my_uart_rx_frame;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  my_uart_rx_frame_if frm ();

  my_uart_rx_frame #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs232_rx (rx),
    .frm      (frm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:8][7:0] pl;
    int              nstop;
    logic [11:0]     x;
    logic [11:0]     y;
    logic [9:0]      ax;
    logic [9:0]      ay;
    logic            dir;
    int              dv;
    int              de;
  } vec_t;

  vec_t vecs [3];
  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;

  // Pulse monitor.
  always @(negedge clk) begin
    if (frm.frame_valid) n_valid = n_valid + 1;
    if (frm.frame_err) n_err = n_err + 1;
    if (frm.frame_valid && frm.frame_err) n_both = n_both + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [11:0] x, input logic [11:0] y,
                         input logic [9:0] ax, input logic [9:0] ay, input logic d);
    chk({tag, " centre_pos_x"}, 32'(frm.centre_pos_x), 32'(x));
    chk({tag, " centre_pos_y"}, 32'(frm.centre_pos_y), 32'(y));
    chk({tag, " angle_x"}, 32'(frm.angle_x), 32'(ax));
    chk({tag, " angle_y"}, 32'(frm.angle_y), 32'(ay));
    chk({tag, " chieu_xoay"}, 32'(frm.chieu_xoay), 32'(d));
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int nstop, input logic stop_val);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_val;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (nstop == 2) repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [0:8][7:0] pl, input int nstop);
    send_byte(8'hFF, nstop, 1'b1);
    send_byte(8'hFF, nstop, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(pl[i], nstop, 1'b1);
  endtask

  logic [0:8][7:0] t1_pl, t2_pl;
  logic [7:0] garbage [5];
  int v0, e0;

  initial begin
    t1_pl = {8'h64, 8'h01, 8'h32, 8'h00, 8'h2D, 8'h00, 8'h5A, 8'h00, 8'h01};
    t2_pl = {8'h00, 8'h00, 8'hFF, 8'h03, 8'hFF, 8'h03, 8'hFF, 8'h03, 8'h01};
    garbage = '{8'h12, 8'hFF, 8'h34, 8'hFF, 8'hFF};

    // T1: x=0x164, y=0x032 pre-shift.
    vecs[0] = '{pl: t1_pl, nstop: 2, x: 12'h590, y: 12'h0C8, ax: 10'd45, ay: 10'd90,
                dir: 1'b1, dv: 1, de: 0};
    // T6: xh=0x05 (reserved bit set); outputs equal T1 either way.
`ifdef UART_RX_FRAME_CHECK_EN
    vecs[1] = '{pl: {8'h64, 8'h05, 8'h32, 8'h00, 8'h2D, 8'h00, 8'h5A, 8'h00, 8'h01},
                nstop: 2, x: 12'h590, y: 12'h0C8, ax: 10'd45, ay: 10'd90,
                dir: 1'b1, dv: 0, de: 1};
`else
    vecs[1] = '{pl: {8'h64, 8'h05, 8'h32, 8'h00, 8'h2D, 8'h00, 8'h5A, 8'h00, 8'h01},
                nstop: 2, x: 12'h590, y: 12'h0C8, ax: 10'd45, ay: 10'd90,
                dir: 1'b1, dv: 1, de: 0};
`endif
    // FF as payload data (xl), 1 stop bit, dir=0.
    vecs[2] = '{pl: {8'hFF, 8'h02, 8'h10, 8'h01, 8'h00, 8'h00, 8'h7B, 8'h01, 8'h00},
                nstop: 1, x: 12'hBFC, y: 12'h440, ax: 10'h000, ay: 10'h17B,
                dir: 1'b0, dv: 1, de: 0};

    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 12'h0, 12'h0, 10'h0, 10'h0, 1'b0);
    chk("reset rx_busy", 32'(frm.rx_busy), 32'd0);
    chk("reset frame_valid", 32'(frm.frame_valid), 32'd0);
    chk("reset frame_err", 32'(frm.frame_err), 32'd0);
    rst_n = 1'b1;
    idle(4);

    // Table of complete frames.
    for (int k = 0; k < 3; k++) begin
      v0 = n_valid; e0 = n_err;
      send_frame(vecs[k].pl, vecs[k].nstop);
      idle(12);
      chk_out($sformatf("vec%0d", k), vecs[k].x, vecs[k].y, vecs[k].ax, vecs[k].ay, vecs[k].dir);
      chk($sformatf("vec%0d valid pulses", k), 32'(n_valid - v0), 32'(vecs[k].dv));
      chk($sformatf("vec%0d err pulses", k), 32'(n_err - e0), 32'(vecs[k].de));
    end

    // T3: 1-cycle start glitch before idx 4.
    v0 = n_valid; e0 = n_err;
    send_byte(8'hFF, 2, 1'b1);
    send_byte(8'hFF, 2, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(t1_pl[i], 2, 1'b1);
    rx = 1'b0;
    @(negedge clk);
    idle(10);
    chk("T3 rx_busy mid-frame", 32'(frm.rx_busy), 32'd1);
    for (int i = 4; i < 9; i++) send_byte(t1_pl[i], 2, 1'b1);
    idle(12);
    chk_out("T3", 12'h590, 12'h0C8, 10'd45, 10'd90, 1'b1);
    chk("T3 valid pulses", 32'(n_valid - v0), 32'd1);
    chk("T3 err pulses", 32'(n_err - e0), 32'd0);

    // T4: stop bit of idx 5 driven low.
    v0 = n_valid; e0 = n_err;
    send_byte(8'hFF, 2, 1'b1);
    send_byte(8'hFF, 2, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(t2_pl[i], 2, 1'b1);
    send_byte(t2_pl[5], 2, 1'b0);
    idle(16);
    chk_out("T4 after ferr", 12'h590, 12'h0C8, 10'd45, 10'd90, 1'b1);
    chk("T4 err pulses", 32'(n_err - e0), 32'd1);
    chk("T4 valid pulses", 32'(n_valid - v0), 32'd0);
    chk("T4 rx_busy after ferr", 32'(frm.rx_busy), 32'd0);
    v0 = n_valid;
    send_frame(vecs[2].pl, 2);
    idle(12);
    chk_out("T4 recovery", 12'hBFC, 12'h440, 10'h000, 10'h17B, 1'b0);
    chk("T4 recovery valid", 32'(n_valid - v0), 32'd1);

    // T2: three back-to-back frames, 1 stop bit.
    v0 = n_valid; e0 = n_err;
    for (int f = 0; f < 3; f++) send_frame(t2_pl, 1);
    idle(12);
    chk_out("T2", 12'h000, 12'hFFC, 10'h3FF, 10'h3FF, 1'b1);
    chk("T2 valid pulses", 32'(n_valid - v0), 32'd3);
    chk("T2 err pulses", 32'(n_err - e0), 32'd0);

    // T5: garbage 12 FF 34 FF FF, sync found on the last FF FF.
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 5; i++) send_byte(garbage[i], 2, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(t1_pl[i], 2, 1'b1);
    idle(12);
    chk_out("T5", 12'h590, 12'h0C8, 10'd45, 10'd90, 1'b1);
    chk("T5 valid pulses", 32'(n_valid - v0), 32'd1);
    chk("T5 err pulses", 32'(n_err - e0), 32'd0);

    // T7: reset for 3 cycles mid-payload.
    send_byte(8'hFF, 2, 1'b1);
    send_byte(8'hFF, 2, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(t2_pl[i], 2, 1'b1);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    v0 = n_valid; e0 = n_err;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("T7 in reset", 12'h0, 12'h0, 10'h0, 10'h0, 1'b0);
    chk("T7 rx_busy in reset", 32'(frm.rx_busy), 32'd0);
    rst_n = 1'b1;
    idle(40);
    chk("T7 rx_busy after reset", 32'(frm.rx_busy), 32'd0);
    chk("T7 valid pulses", 32'(n_valid - v0), 32'd0);
    chk("T7 err pulses", 32'(n_err - e0), 32'd0);
    chk_out("T7 held zero", 12'h0, 12'h0, 10'h0, 10'h0, 1'b0);
    v0 = n_valid;
    send_frame(t2_pl, 2);
    idle(12);
    chk_out("T7 next frame", 12'h000, 12'hFFC, 10'h3FF, 10'h3FF, 1'b1);
    chk("T7 next frame valid", 32'(n_valid - v0), 32'd1);

    chk("valid and err together", 32'(n_both), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
